// File: rtl/oled_pkg.sv
`default_nettype none
// ============================================================================
// Module      : oled_pkg
// Description : Shared types and constants for the OLED frame controller:
//               FSM state encoding, D/C# levels and the init command ROM.
// Revision    : 1.0 - initial release
// ============================================================================
package oled_pkg;

  typedef enum logic [3:0] {
    ST_RST_LO  = 4'd0,
    ST_RST_HI  = 4'd1,
    ST_SETTLE  = 4'd2,
    ST_INIT    = 4'd3,
    ST_IDLE    = 4'd4,
    ST_PG_CMD  = 4'd5,
    ST_PG_DATA = 4'd6,
    ST_W_HI    = 4'd7,
    ST_W_LO    = 4'd8
  } state_e;

  localparam logic OLED_CMD     = 1'b0;
  localparam logic OLED_DAT     = 1'b1;
  localparam int   INIT_CMD_NUM = 27;

  // Init ROM: multiplex ratio and COM pin layout depend on the panel height.
  function automatic logic [7:0] init_byte(input logic [4:0] idx, input int pages,
                                           input logic [7:0] contrast);
    logic [7:0] b;
    case (idx)
      5'd0:    b = 8'hAE;
      5'd1:    b = 8'h00;
      5'd2:    b = 8'h10;
      5'd3:    b = 8'h40;
      5'd4:    b = 8'h81;
      5'd5:    b = contrast;
      5'd6:    b = 8'hA1;
      5'd7:    b = 8'hC8;
      5'd8:    b = 8'hA6;
      5'd9:    b = 8'hA8;
      5'd10:   b = 8'(8 * pages - 1);
      5'd11:   b = 8'hD3;
      5'd12:   b = 8'h00;
      5'd13:   b = 8'hD5;
      5'd14:   b = 8'h80;
      5'd15:   b = 8'hD9;
      5'd16:   b = 8'hF1;
      5'd17:   b = 8'hDA;
      5'd18:   b = (pages == 4) ? 8'h02 : 8'h12;
      5'd19:   b = 8'hDB;
      5'd20:   b = 8'h40;
      5'd21:   b = 8'h20;
      5'd22:   b = 8'h02;
      5'd23:   b = 8'h8D;
      5'd24:   b = 8'h14;
      5'd25:   b = 8'hA4;
      default: b = 8'hAF;
    endcase
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/oled_dirty_tracker.sv
`default_nettype none
// ============================================================================
// Module      : oled_dirty_tracker
// Description : Sticky per-page dirty register with lowest-index-first page
//               selection. A set and a clear of one bit in the same cycle
//               leave the bit set, so a page re-marked mid-send is resent.
// Revision    : 1.0 - initial release
// ============================================================================
module oled_dirty_tracker #(
  parameter int PAGES = 8,
  parameter int PW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             upd_en_i,
  input  logic [PAGES-1:0] set_i,
  input  logic             refresh_i,
  input  logic             set_all_i,
  input  logic             take_i,
  output logic             any_o,
  output logic [PW-1:0]    sel_o
);

  logic [PAGES-1:0] dirty_q, dirty_d;
  logic [PAGES-1:0] w_clr, w_set;

  // Priority encoder: scanning downward leaves the lowest set index in sel_o.
  always_comb begin
    sel_o = '0;
    for (int i = PAGES - 1; i >= 0; i--) begin
      if (dirty_q[i]) sel_o = PW'(i);
    end
  end

  assign any_o = |dirty_q;

  // Next dirty value: clear the taken page first, then OR new requests on top.
  always_comb begin
    w_clr = '0;
    w_set = '0;
    if (take_i)    w_clr = PAGES'(1) << sel_o;
    if (upd_en_i)  w_set = set_i | {PAGES{refresh_i}};
    if (set_all_i) w_set = '1;
    dirty_d = (dirty_q & ~w_clr) | w_set;
  end

  // Dirty register; contents are lost on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dirty_q <= '0;
    else     dirty_q <= dirty_d;
  end

endmodule
`default_nettype wire

// File: rtl/oled_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : oled_frame_ctrl
// Description : SSD1306-class OLED controller: power-on reset, init command
//               stream, then page-by-page frame streaming with dirty-page
//               partial refresh over a byte-wide SPI transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
module oled_frame_ctrl
  import oled_pkg::*;
#(
  parameter int         CLK_FRE      = 50,
  parameter int         RST_MS       = 100,
  parameter int         RST_CYC      = CLK_FRE * 1000 * RST_MS,
  parameter int         COLS         = 128,
  parameter int         PAGES        = 8,
  parameter logic [7:0] CONTRAST     = 8'hFF,
  parameter int         AUTO_REFRESH = 0,
  parameter int         AW           = $clog2(COLS * PAGES)
) (
  input  logic             clk,
  input  logic             rst,
  output logic [AW-1:0]    read_addr,
  input  logic [7:0]       read_data,
  output logic             oled_rst,
  input  logic             send_busy,
  output logic             send_en,
  output logic             send_dc,
  output logic [7:0]       send_data,
  input  logic [PAGES-1:0] dirty,
  input  logic             refresh_req,
  output logic             ready,
  output logic             frame_done
);

  localparam int PW = (PAGES > 1) ? $clog2(PAGES) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  state_e          state_q, state_d;
  state_e          ret_q, ret_d;
  logic [31:0]     cnt_q, cnt_d;
  logic [4:0]      init_idx_q, init_idx_d;
  logic [1:0]      cmd_idx_q, cmd_idx_d;
  logic [CW-1:0]   col_q, col_d;
  logic [PW-1:0]   page_q, page_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [7:0]      data_q, data_d;
  logic            dc_q, dc_d;
  logic            sent_q, sent_d;
  logic            init_done_q, init_done_d;

  logic            w_launch, w_dc, w_set_all, w_take, w_fdone, w_any;
  logic [7:0]      w_byte;
  logic [PW-1:0]   w_sel;

  oled_dirty_tracker #(
    .PAGES (PAGES),
    .PW    (PW)
  ) u_dirty (
    .clk       (clk),
    .rst       (rst),
    .upd_en_i  (init_done_q),
    .set_i     (dirty),
    .refresh_i (refresh_req),
    .set_all_i (w_set_all),
    .take_i    (w_take),
    .any_o     (w_any),
    .sel_o     (w_sel)
  );

  // Launch strobe is combinational so the byte leaves in the same cycle the
  // calling state sees the transmitter free; the hold registers keep D/C and
  // data stable until the next launch.
  assign send_en    = w_launch;
  assign send_dc    = w_launch ? w_dc : dc_q;
  assign send_data  = w_launch ? w_byte : data_q;
  assign read_addr  = addr_q;
  assign oled_rst   = (state_q != ST_RST_LO);
  assign ready      = (state_q == ST_IDLE);
  assign frame_done = w_fdone;

  // Next-state logic, byte launch and page/column sequencing.
  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    cnt_d       = cnt_q;
    init_idx_d  = init_idx_q;
    cmd_idx_d   = cmd_idx_q;
    col_d       = col_q;
    page_d      = page_q;
    addr_d      = addr_q;
    sent_d      = sent_q;
    init_done_d = init_done_q;
    w_launch    = 1'b0;
    w_dc        = OLED_CMD;
    w_byte      = 8'h00;
    w_set_all   = 1'b0;
    w_take      = 1'b0;
    w_fdone     = 1'b0;

    case (state_q)
      ST_RST_LO, ST_RST_HI, ST_SETTLE: begin
        if (cnt_q == 32'(RST_CYC - 1)) begin
          cnt_d = '0;
          case (state_q)
            ST_RST_LO: state_d = ST_RST_HI;
            ST_RST_HI: state_d = ST_SETTLE;
            default: begin
              state_d    = ST_INIT;
              init_idx_d = '0;
            end
          endcase
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      ST_INIT: begin
        if (init_idx_q == 5'(INIT_CMD_NUM)) begin
          w_set_all   = 1'b1;
          init_done_d = 1'b1;
          state_d     = ST_IDLE;
        end else if (!send_busy) begin
          w_launch   = 1'b1;
          w_dc       = OLED_CMD;
          w_byte     = init_byte(init_idx_q, PAGES, CONTRAST);
          init_idx_d = init_idx_q + 5'd1;
          ret_d      = ST_INIT;
          state_d    = ST_W_HI;
        end
      end

      ST_IDLE: begin
        if (w_any) begin
          w_take    = 1'b1;
          page_d    = w_sel;
          addr_d    = AW'(w_sel) * AW'(COLS);
          cmd_idx_d = '0;
          col_d     = '0;
          sent_d    = 1'b1;
          state_d   = ST_PG_CMD;
        end else begin
          if (AUTO_REFRESH != 0) w_set_all = 1'b1;
          if (sent_q) begin
            w_fdone = 1'b1;
            sent_d  = 1'b0;
          end
        end
      end

      ST_PG_CMD: begin
        if (!send_busy) begin
          w_launch = 1'b1;
          w_dc     = OLED_CMD;
          case (cmd_idx_q)
            2'd0:    w_byte = 8'hB0 + 8'(page_q);
            2'd1:    w_byte = 8'h00;
            default: w_byte = 8'h10;
          endcase
          cmd_idx_d = cmd_idx_q + 2'd1;
          ret_d     = (cmd_idx_q == 2'd2) ? ST_PG_DATA : ST_PG_CMD;
          state_d   = ST_W_HI;
        end
      end

      ST_PG_DATA: begin
        if (!send_busy) begin
          w_launch = 1'b1;
          w_dc     = OLED_DAT;
          w_byte   = read_data;
          addr_d   = addr_q + AW'(1);
          col_d    = col_q + CW'(1);
          ret_d    = (col_q == CW'(COLS - 1)) ? ST_IDLE : ST_PG_DATA;
          state_d  = ST_W_HI;
        end
      end

      ST_W_HI: begin
        if (send_busy) state_d = ST_W_LO;
      end

      ST_W_LO: begin
        if (!send_busy) state_d = ret_q;
      end

      default: state_d = ST_RST_LO;
    endcase
  end

  // Launched byte and D/C level are held for the transmitter.
  always_comb begin
    data_d = data_q;
    dc_d   = dc_q;
    if (w_launch) begin
      data_d = w_byte;
      dc_d   = w_dc;
    end
  end

  // State, counters and hold registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RST_LO;
      ret_q       <= ST_RST_LO;
      cnt_q       <= '0;
      init_idx_q  <= '0;
      cmd_idx_q   <= '0;
      col_q       <= '0;
      page_q      <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      dc_q        <= 1'b0;
      sent_q      <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      cnt_q       <= cnt_d;
      init_idx_q  <= init_idx_d;
      cmd_idx_q   <= cmd_idx_d;
      col_q       <= col_d;
      page_q      <= page_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      dc_q        <= dc_d;
      sent_q      <= sent_d;
      init_done_q <= init_done_d;
    end
  end

endmodule
`default_nettype wire
